seq_divider: RTL and testbench

- Sequential unsigned integer divider. It is the inverse companion to the ALU's combinational multiplier.
- Computes op_c = op_a / op_b with a radix-2 restoring algorithm, one quotient bit per clock.
- Uses a start/busy/done handshake, so the ALU can issue a divide and collect the result later without a long combinational path.
- Sits beside the multiplier in the ALU datapath and uses the same 12-bit operand width.

---
 rtl/seq_divider_if.sv | 31 +++
 rtl/seq_divider.sv | 124 ++++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake bundle between the ALU and
// the sequential divider. When SEQ_DIVIDER_REMAINDER_EN is defined the
// bundle also carries the final remainder op_r.
interface seq_divider_if #(
   parameter int WIDTH = 12
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] op_c;
   logic             busy;
   logic             done;
   logic             div_zero;
`ifdef SEQ_DIVIDER_REMAINDER_EN
   logic [WIDTH-1:0] op_r;

   // ALU side: issues operands, collects quotient and remainder
   modport master (output start, op_a, op_b,
                   input  op_c, busy, done, div_zero, op_r);
   // divider side
   modport slave  (input  start, op_a, op_b,
                   output op_c, busy, done, div_zero, op_r);
`else
   // ALU side: issues operands, collects quotient
   modport master (output start, op_a, op_b,
                   input  op_c, busy, done, div_zero);
   // divider side
   modport slave  (input  start, op_a, op_b,
                   output op_c, busy, done, div_zero);
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, one quotient bit per
// clock. A division accepted on edge E0 produces its done pulse after
// edge E0+WIDTH. Optional remainder output: SEQ_DIVIDER_REMAINDER_EN.
module seq_divider #(
   parameter int WIDTH = 12
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (WIDTH < 2) begin : g_width_chk
      $error("seq_divider: WIDTH must be >= 2");
   end

   logic [1:0]       state;
   logic [WIDTH:0]   rem;     // one spare bit so the compare never overflows
   logic [WIDTH-1:0] q;       // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] op_c_q;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;

   logic [WIDTH+1:0] sh;
   logic             ge;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] q_nx;
   logic             accept;
   logic             last;

   // one restoring step: shift {rem,q} left, subtract divisor if it fits.
   // sh is kept one bit wider than rem so the whole remainder feeds the
   // compare; after a subtract the top bits are always zero again.
   always_comb begin
      sh     = {rem, q[WIDTH-1]};
      ge     = (sh >= {2'b00, dvsr});
      rem_nx = ge ? (WIDTH+1)'(sh - {2'b00, dvsr}) : sh[WIDTH:0];
      q_nx   = {q[WIDTH-2:0], ge};
      accept = bus.start && (state != S_RUN);
      last   = (state == S_RUN) && (cnt == CW'(1));
   end

   // control FSM and iteration datapath; start is ignored while running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         rem   <= '0;
         q     <= '0;
         dvsr  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  rem   <= '0;
                  q     <= bus.op_a;
                  dvsr  <= bus.op_b;
                  cnt   <= CW'(WIDTH);
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               rem <= rem_nx;
               q   <= q_nx;
               cnt <= cnt - CW'(1);
               if (last) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // handshake outputs: busy from accept edge to completion edge, done for
   // exactly the DONE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= accept || ((state == S_RUN) && !last);
         done_q <= last;
      end
   end

   // result registers only move on the completion edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_c_q <= '0;
         dz_q   <= 1'b0;
      end else if (last) begin
         op_c_q <= q_nx;
         dz_q   <= (dvsr == '0);
      end
   end

   assign bus.op_c     = op_c_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;

`ifdef SEQ_DIVIDER_REMAINDER_EN
   logic [WIDTH-1:0] op_r_q;

   // final remainder fits in WIDTH bits since it is below the divisor
   // (or equals the dividend when dividing by zero)
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       op_r_q <= '0;
      else if (last) op_r_q <= rem_nx[WIDTH-1:0];
   end

   assign bus.op_r = op_r_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against
// a plain-arithmetic model. Define SEQ_DIVIDER_REMAINDER_EN to also check op_r.
module tb_seq_divider;
   localparam int W = 12;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return {W{1'b1}};
      return a / b;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return a;
      return a % b;
   endfunction

   // issue one division, scramble operands after accept, wait for done
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] c, output logic dz,
                          output logic [W-1:0] r, output int lat, output bit busy_ok);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      lat = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.start = 1'b0;
            bus.op_a  = 12'($urandom);
            bus.op_b  = 12'($urandom);
         end
         if (!bus.done && !bus.busy) busy_ok = 1'b0;
      end while (!bus.done && lat < 40);
      c  = bus.op_c;
      dz = bus.div_zero;
`ifdef SEQ_DIVIDER_REMAINDER_EN
      r  = bus.op_r;
`else
      r  = ref_r(a, b);
`endif
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.op_c !== 12'd0) begin errors++; $display("FAIL reset_op_c got=%0d want=0", bus.op_c); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b want=0", bus.div_zero); end
`ifdef SEQ_DIVIDER_REMAINDER_EN
      checks++; if (bus.op_r !== 12'd0) begin errors++; $display("FAIL reset_op_r got=%0d want=0", bus.op_r); end
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", bus.busy, bus.done); end
   endtask

   task automatic test_basic();
      logic [W-1:0] c, r; logic dz; int lat; bit bok;
      run_div(12'd100, 12'd7, c, dz, r, lat, bok);
      checks++; if (lat !== 13) begin errors++; $display("FAIL basic_latency got=%0d want=13", lat); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", bok); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", bus.busy); end
      checks++; if (c !== 12'd14) begin errors++; $display("FAIL basic_op_c got=%0d want=14", c); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_div_zero got=%b want=0", dz); end
      checks++; if (r !== 12'd2) begin errors++; $display("FAIL basic_op_r got=%0d want=2", r); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
      checks++; if (bus.op_c !== 12'd14) begin errors++; $display("FAIL basic_op_c_hold got=%0d want=14", bus.op_c); end
   endtask

   task automatic test_extremes();
      logic [W-1:0] ea [3];
      logic [W-1:0] eb [3];
      logic [W-1:0] eq [3];
      logic [W-1:0] er [3];
      logic [W-1:0] c, r; logic dz; int lat; bit bok;
      ea = '{12'd4095, 12'd3,    12'd4095};
      eb = '{12'd1,    12'd4095, 12'd4095};
      eq = '{12'd4095, 12'd0,    12'd1};
      er = '{12'd0,    12'd3,    12'd0};
      for (int i = 0; i < 3; i++) begin
         run_div(ea[i], eb[i], c, dz, r, lat, bok);
         checks++; if (c !== eq[i]) begin errors++; $display("FAIL extreme_op_c %0d/%0d got=%0d want=%0d", ea[i], eb[i], c, eq[i]); end
         checks++; if (r !== er[i]) begin errors++; $display("FAIL extreme_op_r %0d/%0d got=%0d want=%0d", ea[i], eb[i], r, er[i]); end
         checks++; if (lat !== 13 || dz !== 1'b0) begin errors++; $display("FAIL extreme_lat_dz got lat=%0d dz=%b want 13/0", lat, dz); end
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] c, r; logic dz; int lat; bit bok;
      run_div(12'd5, 12'd0, c, dz, r, lat, bok);
      checks++; if (c !== 12'd4095) begin errors++; $display("FAIL dz_op_c got=%0d want=4095", c); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", dz); end
      checks++; if (r !== 12'd5) begin errors++; $display("FAIL dz_op_r got=%0d want=5", r); end
      checks++; if (lat !== 13) begin errors++; $display("FAIL dz_latency got=%0d want=13", lat); end
      @(negedge clk);
      checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got=%b want=1", bus.div_zero); end
      run_div(12'd9, 12'd3, c, dz, r, lat, bok);
      checks++; if (c !== 12'd3 || dz !== 1'b0) begin errors++; $display("FAIL dz_after got c=%0d dz=%b want 3/0", c, dz); end
   endtask

   task automatic test_handshake();
      int t [$];
      logic [W-1:0] v [$];
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 12'd50;
      bus.op_b  = 12'd5;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (k == 1) begin bus.op_a = 12'd99; bus.op_b = 12'd9; end
         if (k == 20) bus.start = 1'b0;
         if (bus.done) begin t.push_back(k); v.push_back(bus.op_c); end
      end
      checks++;
      if (t.size() !== 2) begin
         errors++; $display("FAIL hs_pulse_count got=%0d want=2", t.size());
      end else begin
         checks++; if (t[0] !== 13 || v[0] !== 12'd10) begin errors++; $display("FAIL hs_first got t=%0d c=%0d want 13/10", t[0], v[0]); end
         checks++; if (t[1] !== 26 || v[1] !== 12'd11) begin errors++; $display("FAIL hs_second got t=%0d c=%0d want 26/11", t[1], v[1]); end
      end
   endtask

   task automatic test_reset_midop();
      logic [W-1:0] c, r; logic dz; int lat; bit bok; bit saw;
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = 12'd200; bus.op_b = 12'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.op_c !== 12'd0) begin errors++; $display("FAIL midrst_op_c got=%0d want=0", bus.op_c); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done got=%b/%b want 0/0", bus.busy, bus.done); end
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b want=0", saw); end
      run_div(12'd200, 12'd3, c, dz, r, lat, bok);
      checks++; if (c !== 12'd66 || r !== 12'd2 || lat !== 13) begin errors++; $display("FAIL midrst_rerun got c=%0d r=%0d lat=%0d want 66/2/13", c, r, lat); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ba [3];
      logic [W-1:0] bb [3];
      int t [$];
      logic [W-1:0] v [$];
      int idx;
      ba = '{12'd17, 12'd1000, 12'd0};
      bb = '{12'd4,  12'd10,   12'd7};
      @(negedge clk);
      bus.start = 1'b1; bus.op_a = ba[0]; bus.op_b = bb[0];
      idx = 1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin
            t.push_back(k); v.push_back(bus.op_c);
            if (idx < 3) begin
               bus.start = 1'b1; bus.op_a = ba[idx]; bus.op_b = bb[idx];
               idx++;
            end
         end
      end
      checks++;
      if (t.size() !== 3) begin
         errors++; $display("FAIL b2b_count got=%0d want=3", t.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (t[i] !== 13 * (i + 1) || v[i] !== ref_q(ba[i], bb[i])) begin
               errors++; $display("FAIL b2b_%0d got t=%0d c=%0d want %0d/%0d", i, t[i], v[i], 13 * (i + 1), ref_q(ba[i], bb[i]));
            end
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, c, r; logic dz; int lat; bit bok;
      for (int i = 0; i < 40; i++) begin
         a = 12'($urandom);
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = 12'($urandom_range(1, 15));
            default: b = 12'($urandom);
         endcase
         run_div(a, b, c, dz, r, lat, bok);
         checks++;
         if (c !== ref_q(a, b) || r !== ref_r(a, b) || dz !== (b == 0) || lat !== 13 || !bok) begin
            errors++;
            $display("FAIL rand %0d/%0d got c=%0d r=%0d dz=%b lat=%0d busy=%b want c=%0d r=%0d dz=%b lat=13",
                     a, b, c, r, dz, lat, bok, ref_q(a, b), ref_r(a, b), (b == 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_handshake();
      test_reset_midop();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
